// File: rtl/ddice_turn_sched_if.sv
// Roll handshake and dice bus between the turn scheduler and the dual-dice game engine.
interface ddice_turn_sched_if;
    logic       rb;
    logic [3:0] sum;
    logic [2:0] die1;
    logic [2:0] die2;
    logic       game_rst;
    logic       win;
    logic       lose;

    modport master (output rb, sum, die1, die2, game_rst, input win, lose);
    modport slave  (input rb, sum, die1, die2, game_rst, output win, lose);
endinterface

// File: rtl/ddice_turn_sched.sv
// Two-player turn scheduler: drives engine rolls from button-gated dice counters,
// alternates players per game, tallies saturating scores and pulses the engine reset.
module ddice_turn_sched #(
    parameter int SETTLE_CYC = 2,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_a,
    input  logic               btn_b,
    ddice_turn_sched_if.master eng,
    output logic               turn,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               busy
);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, ROLLING, SETTLE, POINT, SCORE, CLEAR} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             res_win;
    logic             act_btn;
    logic             result;
    logic             pt_a;

    assign act_btn = turn ? btn_b : btn_a;
    assign result  = eng.win | eng.lose;
    // A scores on its own win or on B's loss
    assign pt_a    = res_win ^ turn;

    function automatic logic [2:0] next_die(input logic [2:0] d);
        return (d == 3'd6) ? 3'd1 : d + 3'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (act_btn) state_nx = ROLLING;
            ROLLING: if (!act_btn) state_nx = SETTLE;
            SETTLE: begin
                if (result)                                state_nx = SCORE;
                else if (cnt == CNT_W'(SETTLE_CYC - 1))    state_nx = POINT;
            end
            POINT: begin
                if (act_btn)     state_nx = ROLLING;
                else if (result) state_nx = SCORE;
            end
            SCORE:   state_nx = CLEAR;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng.rb       <= 1'b0;
            eng.sum      <= 4'd0;
            eng.die1     <= 3'd1;
            eng.die2     <= 3'd1;
            eng.game_rst <= 1'b0;
            turn         <= 1'b0;
            score_a      <= '0;
            score_b      <= '0;
            busy         <= 1'b0;
            cnt          <= '0;
            res_win      <= 1'b0;
        end else begin
            eng.rb       <= (state_nx == ROLLING);
            eng.game_rst <= (state_nx == CLEAR);
            busy         <= (state_nx != IDLE);

            if (state == ROLLING)     cnt <= '0;
            else if (state == SETTLE) cnt <= cnt + 1'b1;

            if ((state == SETTLE || state == POINT) && state_nx == SCORE)
                res_win <= eng.win;

            case (state)
                ROLLING: begin
                    eng.sum  <= {1'b0, eng.die1} + {1'b0, eng.die2};
                    eng.die1 <= next_die(eng.die1);
                    if (eng.die1 == 3'd6) eng.die2 <= next_die(eng.die2);
                end
                SCORE: begin
                    if (pt_a) begin
                        if (score_a != '1) score_a <= score_a + 1'b1;
                    end else begin
                        if (score_b != '1) score_b <= score_b + 1'b1;
                    end
                end
                CLEAR: begin
                    eng.sum <= 4'd0;
                    turn    <= ~turn;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ddice_turn_sched.sv
// Scoreboard bench for ddice_turn_sched: roll and game expectations are queued at stimulus
// time and popped when rb falls or game_rst pulses.
module tb_ddice_turn_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_a, btn_b;
    logic       turn, busy;
    logic [7:0] score_a, score_b;

    ddice_turn_sched_if eng();

    ddice_turn_sched #(.SETTLE_CYC(2), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .eng(eng),
        .turn(turn), .score_a(score_a), .score_b(score_b), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] sum; logic [2:0] d1; logic [2:0] d2; } roll_t;
    typedef struct { logic [7:0] sa; logic [7:0] sb; logic t; } game_t;

    roll_t roll_q[$];
    game_t game_q[$];
    roll_t r_mon;
    game_t g_mon;

    int n_chk = 0, n_bad = 0;
    int n_gr = 0, n_rb = 0, n_rolls = 0, n_games = 0;
    logic [2:0] m_d1, m_d2;
    logic [7:0] m_sa, m_sb;
    logic       m_turn;
    logic       rb_prev = 1'b0, gr_prev = 1'b0, exp_turn = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            rb_prev <= 1'b0;
            gr_prev <= 1'b0;
        end else begin
            if (rb_prev && !eng.rb) begin
                n_rb++;
                if (roll_q.size() == 0) chk("roll_unexpected", 1, 0);
                else begin
                    r_mon = roll_q.pop_front();
                    chk("sum", eng.sum, r_mon.sum);
                    chk("die1", eng.die1, r_mon.d1);
                    chk("die2", eng.die2, r_mon.d2);
                end
            end
            if (eng.game_rst) begin
                n_gr++;
                chk("gr_vs_rb", eng.rb, 0);
                if (game_q.size() == 0) chk("game_unexpected", 1, 0);
                else begin
                    g_mon = game_q.pop_front();
                    chk("score_a", score_a, g_mon.sa);
                    chk("score_b", score_b, g_mon.sb);
                    exp_turn <= g_mon.t;
                end
            end
            if (gr_prev) begin
                chk("gr_width", eng.game_rst, 0);
                chk("turn", turn, exp_turn);
                chk("clr_sum", eng.sum, 0);
            end
            rb_prev <= eng.rb;
            gr_prev <= eng.game_rst;
        end
    end

    // Active player holds the button for n sampled edges; each of those edges advances the dice once
    task automatic roll(input int n);
        roll_t r;
        r.sum = 4'd0;
        for (int i = 0; i < n; i++) begin
            r.sum = {1'b0, m_d1} + {1'b0, m_d2};
            if (m_d1 == 3'd6) begin
                m_d1 = 3'd1;
                m_d2 = (m_d2 == 3'd6) ? 3'd1 : m_d2 + 3'd1;
            end else m_d1 = m_d1 + 3'd1;
        end
        r.d1 = m_d1;
        r.d2 = m_d2;
        roll_q.push_back(r);
        n_rolls++;
        @(negedge clk);
        if (m_turn) btn_b = 1'b1; else btn_a = 1'b1;
        repeat (n) @(negedge clk);
        btn_a = 1'b0;
        btn_b = 1'b0;
    endtask

    task automatic finish_game(input logic w, input logic l);
        game_t g;
        logic  pt_a;
        int    seen;
        bit    done;
        pt_a = w ? !m_turn : m_turn;
        if (pt_a) begin if (m_sa != 8'hff) m_sa = m_sa + 8'd1; end
        else      begin if (m_sb != 8'hff) m_sb = m_sb + 8'd1; end
        m_turn = ~m_turn;
        g.sa = m_sa; g.sb = m_sb; g.t = m_turn;
        game_q.push_back(g);
        n_games++;
        seen = n_gr;
        done = 1'b0;
        eng.win  = w;
        eng.lose = l;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (n_gr != seen) done = 1'b1;
        end
        if (!done) chk("gr_timeout", 0, 1);
        eng.win  = 1'b0;
        eng.lose = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0; eng.win = 1'b0; eng.lose = 1'b0;
        m_d1 = 3'd1; m_d2 = 3'd1; m_sa = 8'd0; m_sb = 8'd0; m_turn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rb", eng.rb, 0);
        chk("rst_sum", eng.sum, 0);
        chk("rst_die1", eng.die1, 1);
        chk("rst_die2", eng.die2, 1);
        chk("rst_gr", eng.game_rst, 0);
        chk("rst_turn", turn, 0);
        chk("rst_sa", score_a, 0);
        chk("rst_sb", score_b, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // minimum roll by A, B scores on A's loss
        roll(1);
        finish_game(1'b0, 1'b1);
        // B rolls through a die1 wrap and wins
        roll(6);
        finish_game(1'b1, 1'b0);

        // wrong player in IDLE
        btn_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_wrong_rb", eng.rb, 0);
        chk("idle_wrong_busy", busy, 0);
        btn_b = 1'b0;
        @(negedge clk);

        // no result -> POINT, wrong player ignored, same player re-rolls and wins
        roll(2);
        repeat (4) @(negedge clk);
        chk("point_busy", busy, 1);
        chk("point_rb", eng.rb, 0);
        btn_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("point_wrong_rb", eng.rb, 0);
        chk("point_wrong_busy", busy, 1);
        btn_b = 1'b0;
        roll(3);
        finish_game(1'b1, 1'b0);

        // win and lose together credit only the active player
        roll(4);
        finish_game(1'b1, 1'b1);

        // drive A to saturation, then one more point for A
        while (m_sa != 8'hff) begin
            roll(1 + int'($urandom_range(0, 3)));
            finish_game(!m_turn, m_turn);
        end
        roll(2);
        finish_game(!m_turn, m_turn);
        chk("sat_a", score_a, 255);

        // asynchronous reset in the middle of a roll
        @(negedge clk);
        if (m_turn) btn_b = 1'b1; else btn_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_rb", eng.rb, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rb", eng.rb, 0);
        chk("arst_sum", eng.sum, 0);
        chk("arst_sa", score_a, 0);
        chk("arst_sb", score_b, 0);
        chk("arst_busy", busy, 0);
        chk("arst_die1", eng.die1, 1);
        chk("arst_turn", turn, 0);
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("rb_pulses", n_rb, n_rolls);
        chk("gr_pulses", n_gr, n_games);
        chk("roll_q_left", roll_q.size(), 0);
        chk("game_q_left", game_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
